div_radix2_seq: RTL and testbench
=================================

Name: div_radix2_seq

Overview:
Sequential radix-2 restoring divider. Responds to the Fixedpoint unit's en/ready/complete multi-cycle handshake and returns quotient, remainder and a CR field for divw/divwu. It is a drop-in responder behind the existing divider port of the fixed-point execution unit. One operation is in flight at a time, with no internal queue.

Parameters:
W, 32, operand/result width in bits (Word width)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
en  in  1  start request; accepted only while ready=1
uns  in  1  1 = unsigned divide (divwu), 0 = signed (divw); sampled with en
a  in  W  dividend; sampled with en
b  in  W  divisor; sampled with en
ready  out  1  idle, able to accept en
complete  out  1  one-cycle pulse: outputs valid
quotient  out  W  quotient, truncated toward zero
remainder  out  W  remainder, sign of dividend
div_by_zero  out  1  b was 0 for the completed operation
crf  out  4  Cr_field {lt,gt,eq,ov} of the quotient, signed compare against 0; ov = overflow

Behaviour:
- Reset (reset=0, async) values: ready=1, complete=0, quotient=0, remainder=0, div_by_zero=0, crf=0, state IDLE, counter 0.
- States:
  - IDLE: ready=1. en=1 latches |a|, |b|, quotient sign and remainder sign (signs only when uns=0), then goes to ITER.
  - ITER: runs W iterations, one quotient bit per cycle, MSB first. Partial remainder is W+1 bits; trial subtract; restore on negative. Counter counts W-1 down to 0.
  - FIX: applies the sign corrections, registers the outputs, then goes to IDLE.
- Timing: en in cycle t → ready=0 in cycles t+1..t+W+1. In cycle t+W+2: complete=1 for exactly one cycle and ready=1 again.
- A back-to-back en in the complete cycle is legal and is accepted.
- en while ready=0 is ignored. It has no effect on the in-flight operation.
- Special cases are detected in IDLE and skip ITER. They go to FIX directly, so complete arrives in t+2.
  - b=0: quotient=0, remainder=a, div_by_zero=1, crf.ov=1, eq=1.
  - Signed overflow (uns=0, a=0x80000000, b=0xFFFFFFFF): quotient=0, remainder=0, div_by_zero=0, crf.ov=1, eq=1.
- Outputs hold their values after complete until the next completion. They are not cleared by a new en.
- crf for normal completion: lt = quotient[W-1] and gt = ~lt & (quotient≠0), regardless of uns. eq = (quotient==0). ov=0.
- SO accumulation is done outside this block.
- Signed result sign rules:
  - quotient is negated iff a and b signs differ.
  - remainder is negated iff a is negative.
- Unsigned: no sign handling; |x| = x.
- Reset mid-operation aborts immediately. No complete is issued and the block returns to IDLE.

Optional Feature:
Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, count the leading zeros of |a| (n). Pre-shift the dividend left by n and run only max(W-n,1) ITER cycles.
  - complete in t+2+max(W-n,1).
  - a=0 takes 1 iteration.
  - Special cases are unchanged.
- Undefined: fixed W iterations, and no leading-zero logic is synthesised.

Decomposition:
- Pu_types (shared package) provides:
  - Word and Cr_field, already present.
  - A new Div_state enum {DIV_IDLE, DIV_ITER, DIV_FIX}.
  - A DIV_OVF_DIVIDEND constant (0x80000000).
- One sub-module, clz_word: combinational leading-zero count of a W-bit word, output $clog2(W)+1 bits. Instantiated only under DIV_EARLY_OUT_EN.

Test Plan:
- Unsigned: uns=1, a=100, b=7 → complete at t+34, quotient=14, remainder=2, crf={0,1,0,0}.
- Signed truncation: uns=0, a=-7 (0xFFFFFFF9), b=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1), crf.lt=1.
- Divide by zero: a=5, b=0 → complete at t+2, quotient=0, remainder=5, div_by_zero=1, crf={0,0,1,1}.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF, uns=0 → complete at t+2, quotient=0, crf.ov=1.
  - Same operands with uns=1 → quotient=0, remainder=0x80000000, 34-cycle latency.
- Handshake:
  - en pulsed at t+5 mid-operation → ignored; first result unchanged; exactly one complete.
  - en in the complete cycle → second op accepted; its complete W+2 cycles later.
- Reset at t+10 mid-ITER → ready=1, complete=0 and outputs 0 immediately; no spurious complete afterwards.
  - With DIV_EARLY_OUT_EN: a=3, b=1 → complete at t+4, quotient=3.

Source files
------------

// File: rtl/div_radix2_seq_pkg.sv
// div_radix2_seq_pkg: shared word/CR types, divider state encoding and overflow constant
package div_radix2_seq_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] Word;
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic ov;
  } Cr_field;
  typedef enum logic [1:0] {DIV_IDLE, DIV_ITER, DIV_FIX} Div_state;
  localparam Word DIV_OVF_DIVIDEND = 32'h8000_0000;
endpackage

// File: rtl/div_radix2_seq_clz.sv
// clz_word: combinational leading-zero count of a W-bit word (W when the word is zero)
module clz_word #(
  parameter int W = 32
) (
  input  logic [W-1:0]       word,
  output logic [$clog2(W):0] lz
);
  localparam int LW = $clog2(W) + 1;
  // scan upward so the highest set bit is the last to write the count
  always_comb begin
    lz = LW'(W);
    for (int i = 0; i < W; i++) lz = word[i] ? LW'(W - 1 - i) : lz;
  end
endmodule

// File: rtl/div_radix2_seq.sv
// div_radix2_seq: sequential radix-2 restoring divider (divw/divwu); DIV_EARLY_OUT_EN skips leading-zero iterations
module div_radix2_seq
  import div_radix2_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         uns,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         complete,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic [3:0]   crf
);
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};
  Div_state state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_init;
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, zdiv_q, zdiv_d, ovf_q, ovf_d;
  logic [W-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic div_by_zero_q, div_by_zero_d, complete_q, complete_d;
  Cr_field crf_q, crf_d;
  logic [W-1:0] abs_a, abs_b, dvd_init, q_fix, r_fix;
  logic [W:0] rem_shift, diff;
  assign abs_a = (~uns & a[W-1]) ? -a : a;
  assign abs_b = (~uns & b[W-1]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
  logic [CW:0] lz;
  clz_word #(.W(W)) u_clz (.word(abs_a), .lz(lz));
  assign dvd_init = abs_a << lz;
  assign cnt_init = (int'(lz) == W) ? '0 : CW'(W - 1 - int'(lz));
`else
  assign dvd_init = abs_a;
  assign cnt_init = CW'(W - 1);
`endif
  assign rem_shift = {rem_q, quo_q[W-1]};
  assign diff = rem_shift - {1'b0, dvs_q};
  assign q_fix = qneg_q ? -quo_q : quo_q;
  assign r_fix = rneg_q ? -rem_q : rem_q;
  assign ready = state_q == DIV_IDLE;
  assign complete = complete_q;
  assign quotient = quotient_q;
  assign remainder = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign crf = crf_q;
  // next state: latch operands, iterate one quotient bit per cycle, then sign-fix and publish
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zdiv_d = zdiv_q;
    ovf_d = ovf_q;
    quotient_d = quotient_q;
    remainder_d = remainder_q;
    div_by_zero_d = div_by_zero_q;
    crf_d = crf_q;
    complete_d = 1'b0;
    case (state_q)
      DIV_IDLE: if (en) begin
        dvs_d = abs_b;
        rem_d = '0;
        qneg_d = ~uns & (a[W-1] ^ b[W-1]);
        rneg_d = ~uns & a[W-1];
        zdiv_d = b == '0;
        ovf_d = ~uns & (a == MIN_INT) & (&b);
        quo_d = zdiv_d ? a : dvd_init;
        cnt_d = cnt_init;
        state_d = (zdiv_d | ovf_d) ? DIV_FIX : DIV_ITER;
      end
      DIV_ITER: begin
        rem_d = diff[W] ? rem_shift[W-1:0] : diff[W-1:0];
        quo_d = {quo_q[W-2:0], ~diff[W]};
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? DIV_FIX : DIV_ITER;
      end
      DIV_FIX: begin
        quotient_d = (zdiv_q | ovf_q) ? '0 : q_fix;
        remainder_d = zdiv_q ? quo_q : ovf_q ? '0 : r_fix;
        div_by_zero_d = zdiv_q;
        crf_d = (zdiv_q | ovf_q) ? Cr_field'(4'b0011)
                                 : Cr_field'({q_fix[W-1], ~q_fix[W-1] & (|q_fix), ~(|q_fix), 1'b0});
        complete_d = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end
  // state and datapath registers; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zdiv_q <= 1'b0;
      ovf_q <= 1'b0;
      quotient_q <= '0;
      remainder_q <= '0;
      div_by_zero_q <= 1'b0;
      crf_q <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      zdiv_q <= zdiv_d;
      ovf_q <= ovf_d;
      quotient_q <= quotient_d;
      remainder_q <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      crf_q <= crf_d;
      complete_q <= complete_d;
    end
  end
endmodule

// File: tb/tb_div_radix2_seq.sv
// tb_div_radix2_seq: table, hand-sequence and random checks of div_radix2_seq against an arithmetic model
module tb_div_radix2_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic uns = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic ready, complete, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [3:0] crf;
  int total = 0;
  int bad = 0;

  div_radix2_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .en(en), .uns(uns), .a(a), .b(b),
    .ready(ready), .complete(complete), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .crf(crf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic [3:0]  crf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // reference: plain integer division plus the special-case and latency rules
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mu,
                       output logic [31:0] q, output logic [31:0] r, output logic dz,
                       output logic [3:0] c, output int lat);
    int sa, sb, n;
    logic [31:0] ab;
    sa = ma;
    sb = mb;
    if (mb == 0) begin
      q = 0; r = ma; dz = 1; c = 4'b0011; lat = 2;
    end else if (!mu && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
      q = 0; r = 0; dz = 0; c = 4'b0011; lat = 2;
    end else begin
      if (mu) begin
        q = ma / mb; r = ma % mb;
      end else begin
        q = sa / sb; r = sa % sb;
      end
      dz = 0;
      c = {q[31], !q[31] && q != 0, q == 0, 1'b0};
      lat = W + 2;
`ifdef DIV_EARLY_OUT_EN
      ab = (!mu && ma[31]) ? -ma : ma;
      n = 0;
      while (n < W && ab[W-1-n] == 1'b0) n++;
      lat = 2 + ((W - n) > 1 ? (W - n) : 1);
`else
      ab = '0;
      n = 0;
`endif
    end
  endtask

  // call at a negedge: issues en for one cycle and waits for complete, measuring latency
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic ou,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output logic [3:0] c, output int lat, output logic busy_ok,
                        output logic [31:0] q_hold);
    a = oa; b = ob; uns = ou; en = 1'b1;
    lat = -1; busy_ok = 1'b1; q = 'x; r = 'x; dz = 'x; c = 'x; q_hold = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      en = 1'b0;
      if (k == 1) q_hold = quotient;
      if (complete) begin
        lat = k; busy_ok = ready;
        q = quotient; r = remainder; dz = div_by_zero; c = crf;
        break;
      end else if (ready) busy_ok = 1'b0;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] oa, input logic [31:0] ob, input logic ou);
    logic [31:0] q, r, eq, er, qh;
    logic dz, edz, bok;
    logic [3:0] c, ec;
    int lat, elat;
    model(oa, ob, ou, eq, er, edz, ec, elat);
    run_op(oa, ob, ou, q, r, dz, c, lat, bok, qh);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " quotient"}, q, eq);
    chk({tag, " remainder"}, r, er);
    chk({tag, " div_by_zero"}, {31'd0, dz}, {31'd0, edz});
    chk({tag, " crf"}, {28'd0, c}, {28'd0, ec});
    chk({tag, " busy_ready"}, {31'd0, bok}, 32'd1);
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] q, r, qh, ra, rb;
    logic dz, bok;
    logic [3:0] c;
    int lat, ncomp, first_k;
    logic [31:0] first_q;
    vecs[0] = '{32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 4'b0100};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 4'b1000};
    vecs[2] = '{32'd5, 32'd0, 1'b0, 32'd0, 32'd5, 1'b1, 4'b0011};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 1'b0, 4'b0011};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 4'b0010};
    vecs[5] = '{32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 32'd1, 1'b0, 4'b1000};
    vecs[6] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'd3, 32'hFFFF_FFFF, 1'b0, 4'b0100};
    vecs[7] = '{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 4'b0010};
    vecs[8] = '{32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'b1000};
    vecs[9] = '{32'd3, 32'd1, 1'b0, 32'd3, 32'd0, 1'b0, 4'b0100};
    #2;
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset complete", {31'd0, complete}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dz_crf", {27'd0, div_by_zero, crf}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      model(vecs[i].a, vecs[i].b, vecs[i].uns, q, r, dz, c, lat);
      run_op(vecs[i].a, vecs[i].b, vecs[i].uns, q, r, dz, c, ncomp, bok, qh);
      chk($sformatf("vec%0d latency", i), 32'(ncomp), 32'(lat));
      chk($sformatf("vec%0d quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d remainder", i), r, vecs[i].r);
      chk($sformatf("vec%0d div_by_zero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d crf", i), {28'd0, c}, {28'd0, vecs[i].crf});
      chk($sformatf("vec%0d busy_ready", i), {31'd0, bok}, 32'd1);
      @(negedge clk);
    end
    // en while busy must be ignored
    a = 32'd100; b = 32'd7; uns = 1'b1; en = 1'b1;
    model(32'd100, 32'd7, 1'b1, q, r, dz, c, lat);
    ncomp = 0; first_k = -1; first_q = 'x;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      en = (k == 5);
      if (k == 5) begin a = 32'd9; b = 32'd0; uns = 1'b0; end
      if (complete) begin
        ncomp++;
        if (first_k < 0) begin first_k = k; first_q = quotient; end
      end
    end
    chk("busy_en completes", 32'(ncomp), 32'd1);
    chk("busy_en latency", 32'(first_k), 32'(lat));
    chk("busy_en quotient", first_q, q);
    // back-to-back: second en issued in the complete cycle of the first
    @(negedge clk);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, q, r, dz, c, lat, bok, qh);
    chk("b2b first quotient", q, 32'hFFFF_FFFD);
    run_op(32'd1000, 32'd10, 1'b1, q, r, dz, c, ncomp, bok, qh);
    model(32'd1000, 32'd10, 1'b1, ra, rb, dz, c, lat);
    chk("b2b second latency", 32'(ncomp), 32'(lat));
    chk("b2b second quotient", q, 32'd100);
    chk("b2b hold", qh, 32'hFFFF_FFFD);
    // reset in the middle of an iteration
    @(negedge clk);
    a = 32'd100; b = 32'd7; uns = 1'b1; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst ready", {31'd0, ready}, 32'd1);
    chk("midrst complete", {31'd0, complete}, 32'd0);
    chk("midrst quotient", quotient, 32'd0);
    chk("midrst remainder", remainder, 32'd0);
    chk("midrst dz_crf", {27'd0, div_by_zero, crf}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ncomp = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (complete) ncomp++;
    end
    chk("midrst no complete", 32'(ncomp), 32'd0);
    // randomized operations against the model
    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) rb = 0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel < 5) rb = $urandom_range(1, 20);
      else if (sel == 5) ra = $urandom_range(0, 300);
      else if (sel == 6) rb = -$urandom_range(1, 20);
      check_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
